sample_packetizer: RTL and testbench

Parametrised run-length sample packetizer for the logic-capture path. It sits between the channel input synchroniser and the capture-memory writer. It converts a gated sample stream into `{run_count, sample}` packets over a valid/ready interface, and sequences the pre-trigger and post-trigger capture window. When the capture ends, it reports page-aligned begin/end/trigger packet numbers and the trace size in bytes for readback.

---
 rtl/sample_packetizer.sv | 238 +++++++++++++++++++++++
 tb/tb_sample_packetizer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_packetizer.sv
// ============================================================================
// sample_packetizer: run-length sample packetizer with a pre/post-trigger window
// Optional feature macro: SAMPLE_PACKETIZER_DROP_CNT_EN (drop_count). Rev 1.0
// ============================================================================
`default_nettype none

module sample_packetizer #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int PACKET_WIDTH = 32,
    parameter int DEPTH_LOG2   = 25,
    parameter int PAGE_LOG2    = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    trigger,
    input  logic                    sample_en,
    input  logic [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [SAMPLE_WIDTH-1:0] chan_mask,
    input  logic                    rle_en,
    input  logic [31:0]             pre_count_max,
    input  logic [31:0]             total_count_max,
    output logic [PACKET_WIDTH-1:0] pkt_data,
    output logic                    pkt_valid,
    input  logic                    pkt_ready,
    output logic [DEPTH_LOG2-1:0]   pkt_num,
    output logic [1:0]              state,
    output logic                    done,
    output logic [DEPTH_LOG2-1:0]   begin_pa,
    output logic [DEPTH_LOG2-1:0]   end_pa,
    output logic [DEPTH_LOG2-1:0]   trig_pa,
    output logic [31:0]             trace_bytes
`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
    ,
    output logic [31:0]             drop_count
`endif
);

    localparam int RW        = PACKET_WIDTH - SAMPLE_WIDTH;
    localparam int PKT_BYTES = PACKET_WIDTH / 8;
    localparam logic [DEPTH_LOG2-1:0] PAGE_MASK = DEPTH_LOG2'((64'd1 << PAGE_LOG2) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRE   = 2'd1,
        S_POST  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    first_q, first_d;
    logic [SAMPLE_WIDTH-1:0] prev_q, prev_d;
    logic [RW-1:0]           run_q, run_d;
    logic [PACKET_WIDTH-1:0] pkt_data_q, pkt_data_d;
    logic                    pkt_valid_q, pkt_valid_d;
    logic [DEPTH_LOG2-1:0]   pkt_num_q, pkt_num_d;
    logic [31:0]             pre_cnt_q, pre_cnt_d;
    logic [31:0]             post_cnt_q, post_cnt_d;
    logic                    trig_seen_q, trig_seen_d;
    logic [DEPTH_LOG2-1:0]   trig_num_q, trig_num_d;
    logic [DEPTH_LOG2-1:0]   end_num_q, end_num_d;
    logic [31:0]             count_q, count_d;
    logic                    cap_valid_q, cap_valid_d;
    logic                    done_q, done_d;

    logic capturing, emit, busy, accept, is_trig, post_phase;

    always_comb begin
        capturing  = (state_q == S_PRE) || (state_q == S_POST);
        is_trig    = (state_q == S_PRE) && sample_en && trigger;
        emit       = capturing && sample_en &&
                     (first_q || !rle_en || (|((sample_in ^ prev_q) & ~chan_mask)) ||
                      (&run_q) || is_trig);
        busy       = pkt_valid_q && !pkt_ready;
        accept     = emit && !busy;
        post_phase = (state_q == S_POST) || is_trig;

        state_d     = state_q;
        first_d     = first_q;
        prev_d      = prev_q;
        run_d       = run_q;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q && !pkt_ready;
        pkt_num_d   = pkt_num_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        trig_seen_d = trig_seen_q;
        trig_num_d  = trig_num_q;
        end_num_d   = end_num_q;
        count_d     = count_q;
        cap_valid_d = cap_valid_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_PRE;
                    first_d     = 1'b1;
                    run_d       = '0;
                    pkt_num_d   = '1;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    trig_seen_d = 1'b0;
                end
            end
            S_PRE, S_POST: begin
                if (emit) begin
                    // A dropped emit still restarts the run so the next packet's
                    // run length never spans a packet that was lost.
                    run_d   = '0;
                    prev_d  = sample_in;
                    first_d = 1'b0;
                    if (accept) begin
                        pkt_data_d  = {run_q, sample_in};
                        pkt_valid_d = 1'b1;
                        pkt_num_d   = pkt_num_q + 1'b1;
                        if (post_phase)
                            post_cnt_d = post_cnt_q + 32'd1;
                        else if (pre_cnt_q < pre_count_max)
                            pre_cnt_d = pre_cnt_q + 32'd1;
                    end
                end else if (sample_en) begin
                    run_d = run_q + 1'b1;
                end
                if (is_trig) begin
                    state_d     = S_POST;
                    trig_seen_d = 1'b1;
                    trig_num_d  = pkt_num_d;
                end
                if (accept && post_phase && (pre_cnt_d + post_cnt_d == total_count_max))
                    state_d = S_DRAIN;
                if (abort)
                    state_d = S_DRAIN;
            end
            default: begin
                if (!pkt_valid_q) begin
                    end_num_d   = pkt_num_q;
                    count_d     = pre_cnt_q + post_cnt_q;
                    if (!trig_seen_q)
                        trig_num_d = pkt_num_q;
                    cap_valid_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            first_q     <= 1'b1;
            prev_q      <= '0;
            run_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_num_q   <= '1;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            trig_seen_q <= 1'b0;
            trig_num_q  <= '0;
            end_num_q   <= '0;
            count_q     <= '0;
            cap_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            prev_q      <= prev_d;
            run_q       <= run_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_num_q   <= pkt_num_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            trig_seen_q <= trig_seen_d;
            trig_num_q  <= trig_num_d;
            end_num_q   <= end_num_d;
            count_q     <= count_d;
            cap_valid_q <= cap_valid_d;
            done_q      <= done_d;
        end
    end

    logic [DEPTH_LOG2-1:0] end_pa_w, begin_w, begin_pa_w, span_w, trig_pa_w;
    logic [DEPTH_LOG2:0]   count_pa_w;

    // Readback: trim to whole pages; before the first capture everything reads 0.
    always_comb begin
        end_pa_w   = ((end_num_q & PAGE_MASK) == PAGE_MASK) ? end_num_q
                                                            : ((end_num_q & ~PAGE_MASK) - 1'b1);
        begin_w    = end_num_q - count_q[DEPTH_LOG2-1:0] + 1'b1;
        begin_pa_w = begin_w & ~PAGE_MASK;
        span_w     = end_pa_w - begin_pa_w + 1'b1;
        trig_pa_w  = trig_num_q - begin_pa_w;
        if (count_q < 32'((64'd1 << PAGE_LOG2)))
            count_pa_w = '0;
        else if ((span_w == '0) && ({32'd0, count_q} >= (64'd1 << DEPTH_LOG2)))
            count_pa_w = {1'b1, {DEPTH_LOG2{1'b0}}};
        else
            count_pa_w = {1'b0, span_w};
    end

    assign pkt_data    = pkt_data_q;
    assign pkt_valid   = pkt_valid_q;
    assign pkt_num     = pkt_num_q;
    assign state       = state_q;
    assign done        = done_q;
    assign begin_pa    = cap_valid_q ? begin_pa_w : '0;
    assign end_pa      = cap_valid_q ? end_pa_w   : '0;
    assign trig_pa     = cap_valid_q ? trig_pa_w  : '0;
    assign trace_bytes = cap_valid_q ? (32'(count_pa_w) * 32'(PKT_BYTES)) : 32'd0;

`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
    logic [31:0] drop_count_q, drop_count_d;

    always_comb begin
        drop_count_d = drop_count_q;
        if ((state_q == S_IDLE) && start)
            drop_count_d = '0;
        else if (emit && busy && (drop_count_q != '1))
            drop_count_d = drop_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            drop_count_q <= '0;
        else
            drop_count_q <= drop_count_d;
    end

    assign drop_count = drop_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sample_packetizer.sv
// ============================================================================
// tb_sample_packetizer: directed vector bench for sample_packetizer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sample_packetizer;

    logic        clk = 1'b0;
    logic        reset, start, abort, trigger, sample_en, rle_en, pkt_ready;
    logic [15:0] sample_in, chan_mask;
    logic [31:0] pre_count_max, total_count_max;

    logic [31:0] pkt_data, w_pkt_data;
    logic        pkt_valid, w_pkt_valid, done, w_done;
    logic [24:0] pkt_num, begin_pa, end_pa, trig_pa;
    logic [3:0]  w_pkt_num, w_begin_pa, w_end_pa, w_trig_pa;
    logic [1:0]  state, w_state;
    logic [31:0] trace_bytes, w_trace_bytes;
`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
    logic [31:0] drop_count, w_drop_count;
`endif

    sample_packetizer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
        .sample_en(sample_en), .sample_in(sample_in), .chan_mask(chan_mask),
        .rle_en(rle_en), .pre_count_max(pre_count_max), .total_count_max(total_count_max),
        .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .pkt_num(pkt_num), .state(state), .done(done), .begin_pa(begin_pa),
        .end_pa(end_pa), .trig_pa(trig_pa), .trace_bytes(trace_bytes)
`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    sample_packetizer #(.DEPTH_LOG2(4)) dut_w (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .trigger(trigger),
        .sample_en(sample_en), .sample_in(sample_in), .chan_mask(chan_mask),
        .rle_en(rle_en), .pre_count_max(pre_count_max), .total_count_max(total_count_max),
        .pkt_data(w_pkt_data), .pkt_valid(w_pkt_valid), .pkt_ready(pkt_ready),
        .pkt_num(w_pkt_num), .state(w_state), .done(w_done), .begin_pa(w_begin_pa),
        .end_pa(w_end_pa), .trig_pa(w_trig_pa), .trace_bytes(w_trace_bytes)
`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
        , .drop_count(w_drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        en;
        logic [15:0] s;
        logic [15:0] mask;
        logic        rle;
        logic        rdy;
        logic        exp_v;
        logic [31:0] exp_d;
        logic [24:0] exp_n;
    } vec_t;

    vec_t vt[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic en, input logic [15:0] s, input logic [15:0] mask,
                       input logic rle, input logic rdy, input logic ev,
                       input logic [31:0] ed, input logic [24:0] en_num);
        vec_t v;
        v.en = en; v.s = s; v.mask = mask; v.rle = rle; v.rdy = rdy;
        v.exp_v = ev; v.exp_d = ed; v.exp_n = en_num;
        vt.push_back(v);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, pkt_valid, 0);
        check({tag, "_data"},  pkt_data, 0);
        check({tag, "_num"},   pkt_num, 25'h1FF_FFFF);
        check({tag, "_state"}, state, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_begin"}, begin_pa, 0);
        check({tag, "_end"},   end_pa, 0);
        check({tag, "_trig"},  trig_pa, 0);
        check({tag, "_bytes"}, trace_bytes, 0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 50) begin
            tick();
            n++;
        end
        check(name, done, 1);
    endtask

    initial begin
        int n_done;
        int n_valid;

        reset = 1'b1; start = 1'b0; abort = 1'b0; trigger = 1'b0; sample_en = 1'b0;
        rle_en = 1'b1; pkt_ready = 1'b1; sample_in = '0; chan_mask = '0;
        pre_count_max = 32'd1000; total_count_max = 32'd2000;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // Run-length, masking, raw mode and backpressure vectors.
        add(1, 16'h0001, 16'h0000, 1, 1, 1, 32'h0000_0001, 0);
        for (int i = 0; i < 4; i++) add(1, 16'h0001, 16'h0000, 1, 1, 0, 0, 0);
        add(1, 16'h0002, 16'h0000, 1, 1, 1, 32'h0004_0002, 1);
        add(1, 16'h0102, 16'h0100, 1, 1, 0, 0, 1);
        add(1, 16'h0002, 16'h0100, 1, 1, 0, 0, 1);
        add(1, 16'h0102, 16'h0100, 1, 1, 0, 0, 1);
        add(1, 16'h0003, 16'h0100, 1, 1, 1, 32'h0003_0003, 2);
        add(0, 16'h0003, 16'h0000, 1, 1, 0, 0, 2);
        add(1, 16'h0003, 16'h0000, 1, 1, 0, 0, 2);
        add(1, 16'h0003, 16'h0000, 0, 1, 1, 32'h0001_0003, 3);
        add(1, 16'h0003, 16'h0000, 0, 1, 1, 32'h0000_0003, 4);
        add(0, 16'h0003, 16'h0000, 0, 1, 0, 0, 4);
        add(1, 16'h00AA, 16'h0000, 0, 0, 1, 32'h0000_00AA, 5);
        add(1, 16'h00BB, 16'h0000, 0, 0, 1, 32'h0000_00AA, 5);
        add(1, 16'h00CC, 16'h0000, 0, 0, 1, 32'h0000_00AA, 5);
        add(0, 16'h00CC, 16'h0000, 0, 1, 0, 0, 5);
        add(1, 16'h00DD, 16'h0000, 1, 1, 1, 32'h0000_00DD, 6);

        pulse_start();
        check("start_state", state, 1);
        foreach (vt[i]) begin
            sample_en = vt[i].en; sample_in = vt[i].s; chan_mask = vt[i].mask;
            rle_en = vt[i].rle; pkt_ready = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_valid", i), pkt_valid, vt[i].exp_v);
            if (vt[i].exp_v)
                check($sformatf("vec%0d_data", i), pkt_data, vt[i].exp_d);
            check($sformatf("vec%0d_num", i), pkt_num, vt[i].exp_n);
        end
        sample_en = 1'b0; pkt_ready = 1'b1; chan_mask = '0;
`ifdef SAMPLE_PACKETIZER_DROP_CNT_EN
        check("drop_count", drop_count, 2);
`endif

        // Abort in PRE without trigger: 7 packets 0..6.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_drain", state, 3);
        tick();
        check("abort_done", done, 1);
        check("abort_idle", state, 0);
        check("abort_end_pa", end_pa, 3);
        check("abort_begin_pa", begin_pa, 0);
        check("abort_trig_pa", trig_pa, 6);
        check("abort_bytes", trace_bytes, 16);
        tick();
        check("abort_done_pulse", done, 0);

        // Window: pre 8, total 20, trigger at sample 12, stray start in POST.
        pre_count_max = 32'd8; total_count_max = 32'd20; rle_en = 1'b0;
        pulse_start();
        n_done = 0;
        for (int i = 0; i < 60; i++) begin
            sample_en = 1'b1; sample_in = 16'(i); trigger = (i == 12); start = (i == 15);
            tick();
            if (done) n_done++;
            if (i == 12) begin
                check("win_post", state, 2);
                check("win_trig_pkt", pkt_data, 32'd12);
            end
            if (i == 15) check("wrap_15", w_pkt_num, 15);
            if (i == 16) begin
                check("wrap_0", w_pkt_num, 0);
                check("win_num16", pkt_num, 16);
            end
            if (i == 23) check("win_drain", state, 3);
            if (done) break;
        end
        sample_en = 1'b0; trigger = 1'b0; start = 1'b0;
        check("win_end_num", pkt_num, 23);
        check("win_begin_pa", begin_pa, 4);
        check("win_end_pa", end_pa, 23);
        check("win_trig_pa", trig_pa, 8);
        check("win_bytes", trace_bytes, 80);
        check("wrap_begin_pa", w_begin_pa, 4);
        check("wrap_end_pa", w_end_pa, 7);
        check("wrap_trig_pa", w_trig_pa, 8);
        check("wrap_bytes", w_trace_bytes, 16);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) n_done++;
        end
        check("win_done_once", n_done, 1);
        check("win_bytes_hold", trace_bytes, 80);

        // Run saturation with a static input.
        pre_count_max = 32'd1000; total_count_max = 32'd2000; rle_en = 1'b1;
        pulse_start();
        sample_en = 1'b1; sample_in = 16'h5A5A;
        tick();
        check("sat_first", pkt_data, 32'h0000_5A5A);
        n_valid = 0;
        for (int k = 1; k < 65536; k++) begin
            tick();
            if (pkt_valid) n_valid++;
        end
        check("sat_no_extra", n_valid, 0);
        tick();
        check("sat_valid", pkt_valid, 1);
        check("sat_data", pkt_data, 32'hFFFF_5A5A);
        check("sat_num", pkt_num, 1);
        sample_en = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done("sat_done");
        tick();

        // Reset while in POST.
        pre_count_max = 32'd2; total_count_max = 32'd100; rle_en = 1'b0;
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            sample_en = 1'b1; sample_in = 16'(i + 100); trigger = (i == 3);
            tick();
        end
        trigger = 1'b0;
        check("rstpost_state", state, 2);
        reset = 1'b1;
        tick();
        check_reset_vals("rstpost");
        reset = 1'b0; sample_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
